// File: rtl/wide_alu_serial.sv
// Wide-operand ALU responder: one request in, one result out, computed serially
// (CW bits per cycle for ADD/SUB/ONES, two stages for shifts, one cycle for NONE).
module wide_alu_serial #(
  parameter int W  = 512,
  parameter int CW = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_rs1,
  input  logic [W-1:0] req_rs2,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data
);

  localparam int N   = W / CW;
  localparam int SW  = $clog2(W);
  localparam int CSW = $clog2(CW);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_SHRS = 3'd4,
    OP_ONES = 3'd5,
    OP_NONE = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           w_accept;
  logic           r_req_ready;
  logic           r_rsp_valid;
  op_t            r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_sign;
  logic [IW-1:0]  r_idx;
  logic           r_carry;
  logic [CW-1:0]  r_acc;
  logic           r_stage;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_rsp_data;

  logic [CW-1:0]  w_b_chunk;
  logic [CW:0]    w_sum;
  logic [CW-1:0]  w_acc_next;
  logic [SW-1:0]  w_amt_whole;
  logic [SW-1:0]  w_amt_frac;
  logic [W-1:0]   w_res_next;
  logic           w_last;
  logic           w_chunk_op;

  // SHRS fill comes from the latched sign of the original operand, so stage 2
  // extends correctly even when stage 1 shifted by zero.
  function automatic logic [W-1:0] shift_fill(input op_t op, input logic [W-1:0] d,
                                              input logic [SW-1:0] s, input logic sign);
    case (op)
      OP_SHL:  shift_fill = d << s;
      OP_SHR:  shift_fill = d >> s;
      OP_SHRS: shift_fill = (d >> s) | (sign ? ~({W{1'b1}} >> s) : {W{1'b0}});
      default: shift_fill = d;
    endcase
  endfunction

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  assign w_b_chunk   = (r_op == OP_SUB) ? ~r_b[CW-1:0] : r_b[CW-1:0];
  assign w_sum       = {1'b0, r_a[CW-1:0]} + {1'b0, w_b_chunk} + {{CW{1'b0}}, r_carry};
  assign w_acc_next  = r_acc ^ r_a[CW-1:0];
  assign w_amt_whole = {r_b[SW-1:CSW], {CSW{1'b0}}};
  assign w_amt_frac  = {{(SW-CSW){1'b0}}, r_b[CSW-1:0]};
  assign w_chunk_op  = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_ONES);

  // Per-op next working result and end-of-operation detect.
  always_comb begin
    w_res_next = r_res;
    w_last     = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res_next = {w_sum[CW-1:0], r_res[W-1:CW]};
        w_last     = (r_idx == LAST_IDX);
      end
      OP_ONES: begin
        w_res_next = {{(W-CW){1'b0}}, w_acc_next};
        w_last     = (r_idx == LAST_IDX);
      end
      OP_SHL, OP_SHR, OP_SHRS: begin
        if (!r_stage) begin
          w_res_next = shift_fill(r_op, r_a, w_amt_whole, r_sign);
        end else begin
          w_res_next = shift_fill(r_op, r_res, w_amt_frac, r_sign);
        end
        w_last = r_stage;
      end
      default: begin
        w_res_next = {W{1'b0}};
        w_last     = 1'b1;
      end
    endcase
  end

  // Next-state logic and request acceptance.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_next = S_BUSY;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_BUSY;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= (w_state_next == S_IDLE);
      r_rsp_valid <= (w_state_next == S_DONE);
    end
  end

  // Operand latch and serial datapath; chunk ops consume operands LSB-first.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_op       <= OP_ADD;
      r_a        <= {W{1'b0}};
      r_b        <= {W{1'b0}};
      r_sign     <= 1'b0;
      r_idx      <= {IW{1'b0}};
      r_carry    <= 1'b0;
      r_acc      <= {CW{1'b0}};
      r_stage    <= 1'b0;
      r_res      <= {W{1'b0}};
      r_rsp_data <= {W{1'b0}};
    end else if (w_accept) begin
      r_op    <= op_t'(req_op);
      r_a     <= req_rs1;
      r_b     <= req_rs2;
      r_sign  <= req_rs1[W-1];
      r_idx   <= {IW{1'b0}};
      r_carry <= (req_op == 3'd1);
      r_acc   <= {CW{1'b0}};
      r_stage <= 1'b0;
      r_res   <= {W{1'b0}};
    end else if (r_state == S_BUSY) begin
      r_res   <= w_res_next;
      r_stage <= 1'b1;
      r_idx   <= r_idx + IW'(1);
      if (w_chunk_op) begin
        r_a     <= {{CW{1'b0}}, r_a[W-1:CW]};
        r_b     <= {{CW{1'b0}}, r_b[W-1:CW]};
        r_carry <= w_sum[CW];
        r_acc   <= w_acc_next;
      end else begin
        r_a     <= r_a;
        r_b     <= r_b;
        r_carry <= r_carry;
        r_acc   <= r_acc;
      end
      if (w_last) begin
        r_rsp_data <= w_res_next;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
    end else begin
      r_res <= r_res;
    end
  end

endmodule

// File: doc/wide_alu_serial.md
# wide_alu_serial

Multi-cycle responder for wide-operand ALU requests. It accepts one opcode and two `W`-bit operands over a valid/ready request channel and computes the result serially, one `CW`-bit chunk per cycle for add, subtract and XOR-fold, or in two stages for shifts. The result is returned on a valid/ready response channel. It is the retimed counterpart of the single-cycle wide datapath and serves any initiator that issues wide ALU operations in the poplar regression designs.

## Interface
Parameters:
- `W`, 512, operand/result width; must be a multiple of `CW`; `W >= 2*CW`
- `CW`, 32, chunk width processed per cycle
- Derived: `N = W/CW` (chunk count), `SW = $clog2(W)` (shift-amount width)

Ports:
- `clk`  in  1  clock, rising edge
- `arst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request offered
- `req_ready`  out  1  block can accept; equals (state == IDLE)
- `req_op`  in  3  0=ADD, 1=SUB, 2=SHL, 3=SHR, 4=SHRS, 5=ONES, 6=NONE, 7 treated as NONE
- `req_rs1`  in  W  operand 1
- `req_rs2`  in  W  operand 2; `rs2[SW-1:0]` is the shift amount
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  initiator accepts result
- `rsp_data`  out  W  result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `req_ready=1`.
  - On `req_valid && req_ready`, latch op, rs1, rs2; clear chunk index, carry and fold accumulator; go to BUSY.
- BUSY, ADD/SUB:
  - Chunk `i` (LSB first): `r[i] = a[i] + (b[i] or ~b[i]) + c`.
  - Initial carry is 0 for ADD and 1 for SUB. Carry-out is registered into the next chunk.
  - Carry out of chunk N-1 is discarded (modulo 2^W). Takes N cycles.
- BUSY, ONES:
  - Accumulator ^= `rs1[i*CW +: CW]` each cycle for N cycles.
  - Result is the accumulator zero-extended to W.
- BUSY, shifts: two cycles.
  - Cycle 1: shift by `amt & ~(CW-1)` (whole chunks).
  - Cycle 2: shift by `amt % CW`.
  - SHL/SHR fill with 0. SHRS fills with the original `rs1[W-1]`.
  - Amount is unsigned, range 0..W-1. Amount 0 returns rs1 unchanged.
- BUSY, NONE: one cycle; result 0.
- DONE:
  - `rsp_valid=1`; `rsp_data` holds the result and is stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- Requests are never accepted in BUSY or DONE. `req_*` inputs are ignored there, and latched operands are unaffected by input changes.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): state=IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_data=0`, internal registers 0.
- Let the request handshake occur at edge E0. Latency k is N for ADD/SUB/ONES, 2 for SHL/SHR/SHRS, 1 for NONE.
  - `rsp_valid` rises after edge E0+k.
- If `rsp_ready` is high when `rsp_valid` rises, the response completes at edge E0+k+1. `req_ready` is high the following cycle.
  - Minimum request spacing is k+2 cycles.
- Response back-pressure: `rsp_valid` and `rsp_data` are held indefinitely until `rsp_ready`.
- `rsp_data` changes only on the BUSY→DONE edge or reset. It retains the last result in IDLE.
- Reset asserted mid-BUSY or in DONE: the operation is aborted and the response is lost. The block is back in IDLE with outputs at reset values with no clock required.
- `req_valid` and `rsp_ready` may toggle arbitrarily. The `req_valid` high/`req_ready` low combination has no side effects.

## Test plan
- Carry ripple: W=512, ADD, rs1 = all ones, rs2 = 1 → `rsp_data` = 0, `rsp_valid` rises exactly 16 cycles after acceptance. SUB with rs1 = 0, rs2 = 1 → all ones.
- Shifts across chunk boundary:
  - SHL with rs1 = 1, amt = 37 → `512'h20_0000_0000`.
  - SHRS with rs1 = `1<<511`, amt = 4 → top five bits set (`512'hF8` followed by 126 zero hex digits).
  - SHR of the same operand → `1<<507`.
  - All shifts respond 2 cycles after acceptance.
- Fold and NONE:
  - ONES with rs1 chunk i = `1<<i` → `512'hFFFF`.
  - ONES with chunk i = i → 0.
  - Opcodes 6 and 7 → 0 after 1 cycle.
- Back-pressure: hold `rsp_ready=0` for 5 cycles after `rsp_valid` rises while driving `req_valid=1` with new operands.
  - `rsp_data` stays stable and `req_ready` stays 0.
  - The first request's result is delivered, then the new request is accepted in IDLE.
- Reset mid-operation: assert `arst_n=0` at BUSY chunk 7 of an ADD → immediate `rsp_valid=0`, `rsp_data=0`, `req_ready=1`. A subsequent ADD of 3 + 4 returns 7.
- Back-to-back: consecutive requests with `rsp_ready` tied high → each response matches a reference model and spacing equals k+2 cycles.
